// File: rtl/de_pipe_pkg.sv
// Shared opcode/funct constants and the D->E bundle for the decode/execute pipe.
// Every block that decodes instruction words imports these instead of redefining them.
package de_pipe_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  wreg;
        logic        valid;
    } id_ex_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/md_class.sv
// Flags instructions that use the multiply/divide unit or its HI/LO registers.
// Shared by D-stage stall logic and E-stage hazard logic.
module md_class
    import de_pipe_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_md
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_fn_md;

    assign w_op = opcode_of(instr);
    assign w_fn = funct_of(instr);

    always_comb begin
        w_fn_md = 1'b0;
        case (w_fn)
            FN_MULT, FN_MULTU,
            FN_DIV,  FN_DIVU,
            FN_MFHI, FN_MTHI,
            FN_MFLO, FN_MTLO: w_fn_md = 1'b1;
            default:          w_fn_md = 1'b0;
        endcase
    end

    assign is_md = (w_op == OP_SPECIAL) && w_fn_md;

endmodule

// File: rtl/de_pipe.sv
// D->E pipeline register with MD-unit/data-hazard stall and a saturating bubble counter.
// A stall injects a bubble into E but keeps the stalled PC visible there.
module de_pipe
    import de_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            d_instr,
    input  logic [31:0]            d_pc,
    input  logic                   d_valid,
    input  logic [31:0]            d_rs_data,
    input  logic [31:0]            d_rt_data,
    input  logic [31:0]            d_imm_ext,
    input  logic [4:0]             d_wreg,
    input  logic                   data_stall,
    input  logic                   md_start,
    input  logic                   md_busy,
    output logic                   stall_d,
    output logic [31:0]            e_instr,
    output logic [31:0]            e_pc,
    output logic [31:0]            e_rs_data,
    output logic [31:0]            e_rt_data,
    output logic [31:0]            e_imm_ext,
    output logic [4:0]             e_wreg,
    output logic                   e_valid,
    output logic [STALL_CNT_W-1:0] bubble_cnt
);

    logic                   w_is_md;
    logic                   w_md_hazard;
    id_ex_t                 w_d;
    id_ex_t                 w_bubble;
    id_ex_t                 r_e;
    logic [STALL_CNT_W-1:0] r_cnt;

    md_class u_md_class (
        .instr (d_instr),
        .is_md (w_is_md)
    );

    assign w_md_hazard = w_is_md && (md_start || md_busy);
    assign stall_d     = d_valid && (data_stall || w_md_hazard);

    always_comb begin
        w_d         = '0;
        w_d.instr   = d_instr;
        w_d.pc      = d_pc;
        w_d.rs_data = d_rs_data;
        w_d.rt_data = d_rt_data;
        w_d.imm_ext = d_imm_ext;
        w_d.wreg    = d_wreg;
        w_d.valid   = d_valid;
    end

    // Bubbles carry the D-stage PC so the stalled instruction stays traceable.
    always_comb begin
        w_bubble    = '0;
        w_bubble.pc = d_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e <= '0;
        end else if (stall_d || !d_valid) begin
            r_e <= w_bubble;
        end else begin
            r_e <= w_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (stall_d && (r_cnt != {STALL_CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign e_instr    = r_e.instr;
    assign e_pc       = r_e.pc;
    assign e_rs_data  = r_e.rs_data;
    assign e_rt_data  = r_e.rt_data;
    assign e_imm_ext  = r_e.imm_ext;
    assign e_wreg     = r_e.wreg;
    assign e_valid    = r_e.valid;
    assign bubble_cnt = r_cnt;

endmodule

// File: tb/tb_de_pipe.sv
// Scoreboard bench for de_pipe: driver queues expected E-stage state, monitor pops after each edge.
// Counter is built 4 bits wide so saturation is reachable in a short run.
module tb_de_pipe;

    localparam int W = 4;

    localparam logic [31:0] ADDU  = 32'h0022_1821;
    localparam logic [31:0] MFLO  = 32'h0000_2012;
    localparam logic [31:0] MULT  = 32'h0022_0018;
    localparam logic [31:0] LWMD  = 32'h8C22_0018;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  wreg;
        logic        valid;
        logic [W-1:0] cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  d_instr, d_pc, d_rs_data, d_rt_data, d_imm_ext;
    logic         d_valid;
    logic [4:0]   d_wreg;
    logic         data_stall, md_start, md_busy;
    logic         stall_d;
    logic [31:0]  e_instr, e_pc, e_rs_data, e_rt_data, e_imm_ext;
    logic [4:0]   e_wreg;
    logic         e_valid;
    logic [W-1:0] bubble_cnt;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    de_pipe #(.STALL_CNT_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_instr    (d_instr),
        .d_pc       (d_pc),
        .d_valid    (d_valid),
        .d_rs_data  (d_rs_data),
        .d_rt_data  (d_rt_data),
        .d_imm_ext  (d_imm_ext),
        .d_wreg     (d_wreg),
        .data_stall (data_stall),
        .md_start   (md_start),
        .md_busy    (md_busy),
        .stall_d    (stall_d),
        .e_instr    (e_instr),
        .e_pc       (e_pc),
        .e_rs_data  (e_rs_data),
        .e_rt_data  (e_rt_data),
        .e_imm_ext  (e_imm_ext),
        .e_wreg     (e_wreg),
        .e_valid    (e_valid),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of D-stage inputs; expected stall and post-edge count are hand-supplied.
    task automatic step(
        input logic        rst,
        input logic [31:0] ins,
        input logic [31:0] pc,
        input logic [31:0] rs,
        input logic [31:0] rt,
        input logic [31:0] imm,
        input logic [4:0]  wr,
        input logic        v,
        input logic        ds,
        input logic        st,
        input logic        bz,
        input logic        x_stall,
        input logic [W-1:0] x_cnt
    );
        exp_t e;
        @(negedge clk);
        reset = rst; d_instr = ins; d_pc = pc; d_rs_data = rs;
        d_rt_data = rt; d_imm_ext = imm; d_wreg = wr; d_valid = v;
        data_stall = ds; md_start = st; md_busy = bz;
        #1 chk("stall_d", {31'b0, stall_d}, {31'b0, x_stall});
        e = '{instr: '0, pc: '0, rs: '0, rt: '0, imm: '0,
              wreg: '0, valid: 1'b0, cnt: x_cnt};
        if (!rst) begin
            e.pc = pc;
            if (!x_stall && v) begin
                e.instr = ins; e.rs = rs; e.rt = rt;
                e.imm = imm; e.wreg = wr; e.valid = 1'b1;
            end
        end
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("e_instr",    e_instr,             e.instr);
                chk("e_pc",       e_pc,                e.pc);
                chk("e_rs_data",  e_rs_data,           e.rs);
                chk("e_rt_data",  e_rt_data,           e.rt);
                chk("e_imm_ext",  e_imm_ext,           e.imm);
                chk("e_wreg",     {27'b0, e_wreg},     {27'b0, e.wreg});
                chk("e_valid",    {31'b0, e_valid},    {31'b0, e.valid});
                chk("bubble_cnt", {28'b0, bubble_cnt}, {28'b0, e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; d_instr = '0; d_pc = '0; d_rs_data = '0; d_rt_data = '0;
        d_imm_ext = '0; d_wreg = '0; d_valid = 1'b0;
        data_stall = 1'b0; md_start = 1'b0; md_busy = 1'b0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // normal flow
        step(0, ADDU, 32'h3000, 5, 7, 32'h11, 3, 1, 0, 0, 0, 0, 0);
        // mflo under md_busy for 4 cycles, then enters E
        for (int i = 0; i < 4; i++)
            step(0, MFLO, 32'h3004, 9, 8, 0, 4, 1, 0, 0, 1, 1, W'(i + 1));
        step(0, MFLO, 32'h3004, 9, 8, 0, 4, 1, 0, 0, 0, 0, 4);
        // mult on md_start edge
        step(0, MULT, 32'h3008, 6, 2, 0, 0, 1, 0, 1, 0, 1, 5);
        step(0, MULT, 32'h3008, 6, 2, 0, 0, 1, 0, 0, 0, 0, 5);
        // non-MD ignores md_busy and md_start
        step(0, ADDU, 32'h300C, 32'hFFFF_FFFF, 32'h8000_0000, 1, 3, 1, 0, 1, 1, 0, 5);
        // data_stall on non-MD
        step(0, ADDU, 32'h3010, 1, 2, 0, 3, 1, 1, 0, 1, 1, 6);
        step(0, ADDU, 32'h3010, 1, 2, 0, 3, 1, 0, 0, 1, 0, 6);
        // both hazards together: one bubble, one increment
        step(0, MFLO, 32'h3014, 0, 0, 0, 4, 1, 1, 0, 1, 1, 7);
        step(0, MFLO, 32'h3014, 0, 0, 0, 4, 1, 0, 0, 0, 0, 7);
        // funct 0x18 with nonzero opcode is not MD
        step(0, LWMD, 32'h3018, 3, 4, 32'h18, 2, 1, 0, 1, 1, 0, 7);
        // invalid slot: bubble, no stall, no count
        step(0, MFLO, 32'h301C, 1, 1, 1, 4, 0, 1, 1, 1, 0, 7);
        // saturation at 15
        for (int i = 0; i < 10; i++)
            step(0, ADDU, 32'h3020, 1, 2, 0, 3, 1, 1, 0, 0, 1,
                 (i + 8 > 15) ? W'(15) : W'(i + 8));
        // reset mid-stall: stall_d still follows inputs, state clears
        step(1, ADDU, 32'h3020, 1, 2, 0, 3, 1, 1, 0, 0, 1, 0);
        step(0, ADDU, 32'h4000, 32'hA5, 32'h5A, 32'h77, 7, 1, 0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
